ysyx_24070016_exu_ctrl: RTL and testbench
=========================================

// Module: ysyx_24070016_exu_ctrl
// PURPOSE
//  Issue/retire sequencer for the execute stage: accepts one decoded op from IDU over valid/ready,
//  registers its operands, drives them to the EXU for EXEC_LAT cycles and captures the EXU result.
//  Presents the result to WBU over valid/ready. Single op in flight; adds backpressure and flush to the EXU.
// PARAMETERS
//  XLEN      32  datapath width of operands/result
//  EXEC_LAT  1   cycles the EXU inputs are held before result capture; legal range 1..15
//  CNT_W     32  perf counter width (used only with the PERF_EN macro)
// PORTS
//  clk               in   1     single clock, rising edge
//  rst_n             in   1     asynchronous, active-low reset
//  flush             in   1     synchronous squash of the in-flight op
//  in_valid          in   1     IDU op valid
//  in_ready          out  1     ctrl can accept an op this cycle
//  in_src1           in   XLEN  rs1 value
//  in_src2           in   XLEN  rs2 value
//  in_imm            in   XLEN  immediate
//  in_sel_rs2Isimm   in   1     ALU src2 selects imm
//  in_rd             in   5     destination register
//  in_rf_wen         in   1     op writes the register file
//  exu_src1          out  XLEN  registered operand to EXU
//  exu_src2          out  XLEN  registered operand to EXU
//  exu_imm           out  XLEN  registered immediate to EXU
//  exu_sel_rs2Isimm  out  1     registered select to EXU
//  exu_result        in   XLEN  EXU wrback_result (combinational from exu_* outputs)
//  out_valid         out  1     result valid to WBU
//  out_ready         in   1     WBU accepts the result
//  out_result        out  XLEN  captured result
//  out_rd            out  5     destination register of the result
//  out_rf_wen        out  1     write enable of the result
//  busy              out  1     state != IDLE
//  perf_issue_cnt    out  CNT_W ops accepted (PERF_EN only)
//  perf_stall_cnt    out  CNT_W cycles with out_valid & !out_ready (PERF_EN only)
// BEHAVIOUR
//  - Reset (rst_n=0, any time, mid-op included): state=IDLE; all registered outputs and counters are 0. No op survives.
//  - FSM IDLE/EXEC/DONE. in_ready = !flush & (IDLE | (DONE & out_ready)). Accept = in_valid & in_ready.
//  - Accept: latch src1/src2/imm/sel/rd/rf_wen; cnt<=EXEC_LAT-1; go to EXEC.
//  - EXEC: exu_* are stable. If cnt==0, capture exu_result/rd/rf_wen into out_* and go to DONE; else cnt--.
//  - Latency: op accepted in cycle 0 -> out_valid=1 in cycle EXEC_LAT+1. Throughput is 1 op per EXEC_LAT+1 cycles.
//  - DONE: out_valid=1; out_* are held stable until out_ready. On out_ready: accept -> EXEC (back-to-back), else -> IDLE.
//  - out_valid is 0 in IDLE and EXEC. Valid must never drop without a handshake, except on flush/reset.
//  - flush has top priority in any state: next state IDLE, out_valid=0 next cycle, and a same-cycle in_valid is not accepted.
//    A same-cycle out handshake still completes: WBU consumes the result.
//  - flush while IDLE: no effect. Operand registers keep their values after flush; only state and valid clear.
//  - cnt is 4 bits; EXEC_LAT outside 1..15 is a configuration error (elaboration-time check).
// CONFIGURATION
//  YSYX_24070016_EXU_CTRL_PERF_EN defined:
//  - perf_issue_cnt increments on every accept.
//  - perf_stall_cnt increments on every out_valid & !out_ready cycle.
//  - Both counters wrap modulo 2^CNT_W and are reset by rst_n only, not by flush.
//  Not defined: the perf ports are absent and no counter flops exist.
// STRUCTURE
//  - Package ysyx_24070016_pkg: XLEN default, FSM state encoding (IDLE=2'd0, EXEC=2'd1, DONE=2'd2), REG_ADDR_W=5.
//  - Sub-module ysyx_24070016_exu_ctrl_perf: the two counters, instantiated under the macro.
//  - EXU is instantiated by the parent, not inside this block.
// TESTING
//  1. Reset, EXEC_LAT=1: src1=5, imm=7, sel=1, rd=3, accepted in cycle 0; EXU model adds src1 and src2/imm
//     -> out_valid in cycle 2, out_result=12, out_rd=3.
//  2. EXEC_LAT=3, same op -> out_valid first in cycle 4; exu_* stable during cycles 1..3; in_ready=0 during cycles 1..4.
//  3. Hold out_ready=0 for 5 cycles in DONE -> out_* unchanged, stall_cnt=5 (PERF_EN);
//     then out_ready=1 with in_valid=1 -> new op accepted the same cycle, out_valid low the next cycle.
//  4. Assert flush in EXEC (cycle 1, EXEC_LAT=3) -> IDLE in cycle 2, no out_valid; a same-cycle in_valid is not accepted.
//  5. Drop rst_n asynchronously mid-EXEC -> busy, out_valid and counters go to 0 immediately; the next op behaves as in test 1.
//  6. 100 back-to-back ops with random out_ready -> results are in order with none lost;
//     perf_issue_cnt=100 (PERF_EN); ports are absent when the macro is undefined.

Source files
------------

// File: rtl/ysyx_24070016_pkg.sv
// Shared definitions for the execute-stage issue/retire sequencer:
// datapath defaults, register address width and FSM state encoding.
package ysyx_24070016_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int LAT_CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } exu_state_t;

  // Reload value of the EXEC countdown for a given latency.
  function automatic logic [LAT_CNT_W-1:0] lat_to_cnt(input int lat);
    return LAT_CNT_W'(lat - 1);
  endfunction

endpackage

// File: rtl/ysyx_24070016_exu_ctrl_perf.sv
// Performance counters for the execute sequencer: accepted ops and output stall cycles.
// Both wrap modulo 2^CNT_W and are cleared only by rst_n.
module ysyx_24070016_exu_ctrl_perf #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue,
  input  logic             stall,
  output logic [CNT_W-1:0] issue_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (issue) issue_cnt <= issue_cnt + 1'b1;
      if (stall) stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ysyx_24070016_exu_ctrl.sv
// Execute-stage issue/retire sequencer: one op in flight, IDLE/EXEC/DONE FSM.
// Optional perf counters are built when YSYX_24070016_EXU_CTRL_PERF_EN is defined.
module ysyx_24070016_exu_ctrl
  import ysyx_24070016_pkg::*;
#(
  parameter int XLEN     = ysyx_24070016_pkg::XLEN,
  parameter int EXEC_LAT = 1,
  parameter int CNT_W    = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [XLEN-1:0]       in_src1,
  input  logic [XLEN-1:0]       in_src2,
  input  logic [XLEN-1:0]       in_imm,
  input  logic                  in_sel_rs2Isimm,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_rf_wen,
  output logic [XLEN-1:0]       exu_src1,
  output logic [XLEN-1:0]       exu_src2,
  output logic [XLEN-1:0]       exu_imm,
  output logic                  exu_sel_rs2Isimm,
  input  logic [XLEN-1:0]       exu_result,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_result,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  out_rf_wen,
  output logic                  busy,
  output logic [1:0]            fsm_state
`ifdef YSYX_24070016_EXU_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0]      perf_issue_cnt,
  output logic [CNT_W-1:0]      perf_stall_cnt
`endif
);

  if (EXEC_LAT < 1 || EXEC_LAT > 15) begin : g_lat_err
    $error("ysyx_24070016_exu_ctrl: EXEC_LAT must be in 1..15");
  end
  if (CNT_W < 1) begin : g_cnt_err
    $error("ysyx_24070016_exu_ctrl: CNT_W must be at least 1");
  end

  localparam logic [LAT_CNT_W-1:0] CNT_LOAD = lat_to_cnt(EXEC_LAT);

  exu_state_t           state_q, state_d;
  logic [LAT_CNT_W-1:0] cnt_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic                 rf_wen_q;
  logic                 accept;
  logic                 capture;

  // Handshakes: a transfer happens on a cycle where valid & ready are both high
  // at the rising edge; the producer holds valid and payload until then.
  assign in_ready  = !flush && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign capture   = !flush && (state_q == EXEC) && (cnt_q == '0);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign fsm_state = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    if (cnt_q == '0) state_d = DONE;
      DONE:    if (out_ready) state_d = accept ? EXEC : IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Operand and result registers survive a flush; only state/valid are squashed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exu_src1         <= '0;
      exu_src2         <= '0;
      exu_imm          <= '0;
      exu_sel_rs2Isimm <= 1'b0;
      rd_q             <= '0;
      rf_wen_q         <= 1'b0;
      cnt_q            <= '0;
      out_result       <= '0;
      out_rd           <= '0;
      out_rf_wen       <= 1'b0;
    end else begin
      if (accept) begin
        exu_src1         <= in_src1;
        exu_src2         <= in_src2;
        exu_imm          <= in_imm;
        exu_sel_rs2Isimm <= in_sel_rs2Isimm;
        rd_q             <= in_rd;
        rf_wen_q         <= in_rf_wen;
        cnt_q            <= CNT_LOAD;
      end else if ((state_q == EXEC) && (cnt_q != '0)) begin
        cnt_q <= cnt_q - 1'b1;
      end
      if (capture) begin
        out_result <= exu_result;
        out_rd     <= rd_q;
        out_rf_wen <= rf_wen_q;
      end
    end
  end

`ifdef YSYX_24070016_EXU_CTRL_PERF_EN
  ysyx_24070016_exu_ctrl_perf #(
    .CNT_W(CNT_W)
  ) u_perf (
    .clk      (clk),
    .rst_n    (rst_n),
    .issue    (accept),
    .stall    (out_valid && !out_ready),
    .issue_cnt(perf_issue_cnt),
    .stall_cnt(perf_stall_cnt)
  );
`endif

endmodule

// File: tb/tb_ysyx_24070016_exu_ctrl.sv
// Bench for ysyx_24070016_exu_ctrl: DUT a with EXEC_LAT=1, DUT b with EXEC_LAT=3,
// directed vectors feeding expected-result queues popped by per-DUT monitors.
module tb_ysyx_24070016_exu_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // ---------------- DUT a: EXEC_LAT = 1 ----------------
  logic a_flush = 0, a_in_valid = 0, a_in_ready, a_sel = 0, a_wen = 0;
  logic [31:0] a_src1 = 0, a_src2 = 0, a_imm = 0;
  logic [4:0]  a_rd = 0;
  logic [31:0] a_exu_src1, a_exu_src2, a_exu_imm, a_exu_result, a_out_result;
  logic a_exu_sel, a_out_valid, a_out_ready = 0, a_out_wen, a_busy;
  logic [4:0] a_out_rd;
  logic [1:0] a_state;
`ifdef YSYX_24070016_EXU_CTRL_PERF_EN
  logic [31:0] a_perf_issue, a_perf_stall;
`endif
  assign a_exu_result = a_exu_src1 + (a_exu_sel ? a_exu_imm : a_exu_src2);

  ysyx_24070016_exu_ctrl #(.XLEN(32), .EXEC_LAT(1), .CNT_W(32)) u_a (
    .clk(clk), .rst_n(rst_n), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_src1(a_src1), .in_src2(a_src2), .in_imm(a_imm),
    .in_sel_rs2Isimm(a_sel), .in_rd(a_rd), .in_rf_wen(a_wen),
    .exu_src1(a_exu_src1), .exu_src2(a_exu_src2), .exu_imm(a_exu_imm),
    .exu_sel_rs2Isimm(a_exu_sel), .exu_result(a_exu_result),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_result(a_out_result), .out_rd(a_out_rd), .out_rf_wen(a_out_wen),
    .busy(a_busy), .fsm_state(a_state)
`ifdef YSYX_24070016_EXU_CTRL_PERF_EN
    , .perf_issue_cnt(a_perf_issue), .perf_stall_cnt(a_perf_stall)
`endif
  );

  // ---------------- DUT b: EXEC_LAT = 3 ----------------
  logic b_flush = 0, b_in_valid = 0, b_in_ready, b_sel = 0, b_wen = 0;
  logic [31:0] b_src1 = 0, b_src2 = 0, b_imm = 0;
  logic [4:0]  b_rd = 0;
  logic [31:0] b_exu_src1, b_exu_src2, b_exu_imm, b_exu_result, b_out_result;
  logic b_exu_sel, b_out_valid, b_out_ready = 0, b_out_wen, b_busy;
  logic [4:0] b_out_rd;
  logic [1:0] b_state;
`ifdef YSYX_24070016_EXU_CTRL_PERF_EN
  logic [31:0] b_perf_issue, b_perf_stall;
`endif
  assign b_exu_result = b_exu_src1 + (b_exu_sel ? b_exu_imm : b_exu_src2);

  ysyx_24070016_exu_ctrl #(.XLEN(32), .EXEC_LAT(3), .CNT_W(32)) u_b (
    .clk(clk), .rst_n(rst_n), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_src1(b_src1), .in_src2(b_src2), .in_imm(b_imm),
    .in_sel_rs2Isimm(b_sel), .in_rd(b_rd), .in_rf_wen(b_wen),
    .exu_src1(b_exu_src1), .exu_src2(b_exu_src2), .exu_imm(b_exu_imm),
    .exu_sel_rs2Isimm(b_exu_sel), .exu_result(b_exu_result),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_result(b_out_result), .out_rd(b_out_rd), .out_rf_wen(b_out_wen),
    .busy(b_busy), .fsm_state(b_state)
`ifdef YSYX_24070016_EXU_CTRL_PERF_EN
    , .perf_issue_cnt(b_perf_issue), .perf_stall_cnt(b_perf_stall)
`endif
  );

  // ---------------- scoreboards: {result, rd, rf_wen} ----------------
  logic [37:0] a_exp_q[$];
  logic [37:0] b_exp_q[$];
  int a_pops = 0;
  int b_pops = 0;

  initial begin : mon_a
    logic pv, phs, pfl;
    logic [37:0] pdata, data;
    pv = 0; phs = 0; pfl = 0; pdata = '0;
    forever begin
      @(negedge clk);
      data = {a_out_result, a_out_rd, a_out_wen};
      if (!rst_n) begin
        pv = 0;
      end else begin
        if (pv && !phs && !pfl) begin
          check("a_hold_valid", a_out_valid, 1);
          check("a_hold_data", data, pdata);
        end
        if (a_out_valid && a_out_ready) begin
          if (a_exp_q.size() == 0) check("a_unexpected_result", data, 0);
          else begin
            check("a_result", data, a_exp_q.pop_front());
            a_pops++;
          end
        end
        pv = a_out_valid; phs = a_out_valid && a_out_ready; pfl = a_flush; pdata = data;
      end
    end
  end

  initial begin : mon_b
    logic [37:0] data;
    forever begin
      @(negedge clk);
      data = {b_out_result, b_out_rd, b_out_wen};
      if (rst_n && b_out_valid && b_out_ready) begin
        if (b_exp_q.size() == 0) check("b_unexpected_result", data, 0);
        else begin
          check("b_result", data, b_exp_q.pop_front());
          b_pops++;
        end
      end
    end
  end

  function automatic logic [37:0] model(input logic [31:0] s1, input logic [31:0] s2,
                                        input logic [31:0] im, input logic sel,
                                        input logic [4:0] rd, input logic wen);
    logic [31:0] r;
    r = s1 + (sel ? im : s2);
    return {r, rd, wen};
  endfunction

  task automatic a_issue(input logic [31:0] s1, input logic [31:0] s2, input logic [31:0] im,
                         input logic sel, input logic [4:0] rd, input logic wen);
    int n;
    n = 0;
    a_src1 = s1; a_src2 = s2; a_imm = im; a_sel = sel; a_rd = rd; a_wen = wen;
    a_in_valid = 1;
    @(negedge clk);
    while (!a_in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!a_in_ready) begin
      check("a_issue_timeout", 0, 1);
      a_in_valid = 0;
      return;
    end
    a_exp_q.push_back(model(s1, s2, im, sel, rd, wen));
    @(posedge clk);
    #1 a_in_valid = 0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit done;
    int base;
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", a_busy, 0);
    check("rst_out_valid", a_out_valid, 0);
    check("rst_out_result", a_out_result, 0);
    check("rst_exu_src1", a_exu_src1, 0);
    #1 rst_n = 1;
    @(negedge clk);
    check("rst_in_ready", a_in_ready, 1);
    check("rst_state", a_state, 0);
    check("rst_b_busy", b_busy, 0);

    // Test 1: EXEC_LAT=1, 5 + imm 7 -> 12 in cycle 2
    cyc();
    a_src1 = 5; a_src2 = 100; a_imm = 7; a_sel = 1; a_rd = 3; a_wen = 1;
    a_in_valid = 1; a_out_ready = 0;
    @(negedge clk); check("t1_in_ready_c0", a_in_ready, 1);
    cyc(); a_in_valid = 0; a_exp_q.push_back(model(5, 100, 7, 1, 3, 1));
    @(negedge clk);
    check("t1_out_valid_c1", a_out_valid, 0);
    check("t1_busy_c1", a_busy, 1);
    check("t1_exu_ops_c1", {a_exu_src1, a_exu_imm, 31'd0, a_exu_sel}, {32'd5, 32'd7, 32'd1});
    cyc(); @(negedge clk);
    check("t1_out_valid_c2", a_out_valid, 1);
    check("t1_out_result_c2", a_out_result, 12);
    check("t1_out_rd_c2", a_out_rd, 3);
    check("t1_in_ready_c2", a_in_ready, 0);

    // Test 3: stall 5 cycles (2..6), then back-to-back accept in cycle 7
    repeat (4) cyc();
    cyc();
    a_out_ready = 1;
    a_src1 = 10; a_src2 = 20; a_imm = 99; a_sel = 0; a_rd = 4; a_wen = 0; a_in_valid = 1;
    @(negedge clk);
    check("t3_in_ready_c7", a_in_ready, 1);
    check("t3_result_held", a_out_result, 12);
`ifdef YSYX_24070016_EXU_CTRL_PERF_EN
    check("t3_stall_cnt", a_perf_stall, 5);
`endif
    cyc(); a_in_valid = 0; a_exp_q.push_back(model(10, 20, 99, 0, 4, 0));
    @(negedge clk);
    check("t3_out_valid_c8", a_out_valid, 0);
    check("t3_busy_c8", a_busy, 1);
    cyc(); @(negedge clk);
    check("t3_out_valid_c9", a_out_valid, 1);
    check("t3_out_result_c9", a_out_result, 30);
    cyc(); a_out_ready = 0;
    @(negedge clk); check("t3_idle_c10", a_busy, 0);

    // Test 2: EXEC_LAT=3 on b, result first valid in cycle 4
    cyc();
    b_src1 = 5; b_src2 = 100; b_imm = 7; b_sel = 1; b_rd = 3; b_wen = 1;
    b_in_valid = 1; b_out_ready = 0;
    @(negedge clk); check("t2_in_ready_c0", b_in_ready, 1);
    cyc(); b_in_valid = 0; b_exp_q.push_back(model(5, 100, 7, 1, 3, 1));
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check($sformatf("t2_out_valid_c%0d", c), b_out_valid, 0);
      check($sformatf("t2_in_ready_c%0d", c), b_in_ready, 0);
      check($sformatf("t2_exu_ops_c%0d", c), {b_exu_src1, b_exu_imm}, {32'd5, 32'd7});
      cyc();
    end
    @(negedge clk);
    check("t2_out_valid_c4", b_out_valid, 1);
    check("t2_in_ready_c4", b_in_ready, 0);
    check("t2_out_result_c4", b_out_result, 12);
    cyc(); b_out_ready = 1;
    cyc(); @(negedge clk);
    check("t2_idle", b_busy, 0);
    check("t2_popped", b_pops, 1);

    // Test 4: flush in EXEC (cycle 1), same-cycle in_valid rejected
    cyc();
    b_src1 = 1; b_src2 = 2; b_imm = 0; b_sel = 0; b_rd = 9; b_wen = 1; b_in_valid = 1;
    cyc();
    b_src1 = 77; b_flush = 1;
    @(negedge clk);
    check("t4_state_c1", b_state, 1);
    check("t4_in_ready_flush", b_in_ready, 0);
    cyc(); b_flush = 0; b_in_valid = 0;
    @(negedge clk);
    check("t4_busy_c2", b_busy, 0);
    check("t4_out_valid_c2", b_out_valid, 0);
    check("t4_operand_kept", b_exu_src1, 1);
    repeat (4) cyc();
    @(negedge clk);
    check("t4_still_idle", b_busy, 0);
    b_out_ready = 0;

    // Test 5: async reset mid-EXEC on a
    cyc();
    a_src1 = 40; a_src2 = 2; a_imm = 0; a_sel = 0; a_rd = 7; a_wen = 1; a_in_valid = 1;
    cyc(); a_in_valid = 0;
    #2 rst_n = 0;
    #1;
    check("t5_busy", a_busy, 0);
    check("t5_out_valid", a_out_valid, 0);
    check("t5_out_result", a_out_result, 0);
    check("t5_exu_src1", a_exu_src1, 0);
`ifdef YSYX_24070016_EXU_CTRL_PERF_EN
    check("t5_issue_cnt", a_perf_issue, 0);
    check("t5_stall_cnt", a_perf_stall, 0);
`endif
    cyc(); rst_n = 1;
    cyc();
    a_src1 = 5; a_src2 = 100; a_imm = 7; a_sel = 1; a_rd = 3; a_wen = 1;
    a_in_valid = 1; a_out_ready = 1;
    @(negedge clk); check("t5_in_ready_c0", a_in_ready, 1);
    cyc(); a_in_valid = 0; a_exp_q.push_back(model(5, 100, 7, 1, 3, 1));
    @(negedge clk); check("t5_out_valid_c1", a_out_valid, 0);
    cyc(); @(negedge clk);
    check("t5_out_valid_c2", a_out_valid, 1);
    check("t5_out_result_c2", a_out_result, 12);
    cyc(); a_out_ready = 0;

    // Test 6: 100 back-to-back ops with random out_ready
    rst_n = 0;
    cyc(); rst_n = 1;
    base = a_pops;
    done = 0;
    fork
      begin
        for (int i = 0; i < 100; i++)
          a_issue($urandom, $urandom, $urandom, 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
        done = 1;
      end
      begin
        while (!done) begin
          cyc();
          a_out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    a_out_ready = 1;
    for (int k = 0; k < 50 && a_exp_q.size() != 0; k++) @(negedge clk);
    check("t6_queue_drained", a_exp_q.size(), 0);
    check("t6_results_count", a_pops - base, 100);
`ifdef YSYX_24070016_EXU_CTRL_PERF_EN
    check("t6_issue_cnt", a_perf_issue, 100);
`endif
    cyc(); a_out_ready = 0;
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
